// File: rtl/freq_bcd_conv.sv
// Binary-to-BCD converter for the frequency display path: serial shift-add-3, one bit per cycle.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF (LCD blank code).
module freq_bcd_conv #(
  parameter int DATA_W = 30,
  parameter int DIGITS = 9
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_W-1:0]     data_fx,
  input  logic                  data_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  ovf,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] max_dec();
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < DIGITS; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_dec();
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // Handshake: data_fx is taken on any edge where data_valid=1 while idle;
  // bcd_valid is a one-cycle strobe, there is no backpressure.
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q;
  logic [BCD_W-1:0]    scratch_q;
  logic [BCD_W-1:0]    scratch_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_pend_q;
  logic [BCD_W-1:0]    result;
  logic [BCD_W-1:0]    result_fmt;

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] v);
    logic lead;
    blank_lz = v;
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (v[4*d +: 4] == 4'd0)) blank_lz[4*d +: 4] = 4'hF;
      else lead = 1'b0;
    end
  endfunction
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (data_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Nibbles >= 5 are corrected before the shift so they carry correctly into the next digit.
  always_comb begin
    scratch_adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    result = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
`ifdef LEADING_ZERO_BLANK_EN
    result_fmt = blank_lz(result);
`else
    result_fmt = result;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_out    <= '0;
      ovf        <= 1'b0;
      bcd_valid  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (data_valid) begin
            shreg_q    <= data_fx;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (64'(data_fx) > MAX_VAL);
          end
        end
        SHIFT: begin
          scratch_q <= {scratch_adj[BCD_W-2:0], shreg_q[DATA_W-1]};
          shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
          cnt_q     <= cnt_q + 1'b1;
        end
        DONE: begin
          bcd_out   <= result_fmt;
          ovf       <= ovf_pend_q;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: doc/freq_bcd_conv.md
FREQ_BCD_CONV -- requirements
Module: freq_bcd_conv

Interface
REQ-001 SHALL have parameter DATA_W, default 30, width of binary frequency input in Hz.
REQ-002 SHALL have parameter DIGITS, default 9, number of BCD output digits.
REQ-003 SHALL have port sys_clk  input  1  single clock for all logic.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port data_fx  input  DATA_W  measured frequency in Hz, from the frequency-measurement stage.
REQ-006 SHALL have port data_valid  input  1  one-cycle strobe marking data_fx valid.
REQ-007 SHALL have port bcd_out  output  4*DIGITS  BCD digits, most significant digit in the top nibble, to the LCD display stage.
REQ-008 SHALL have port bcd_valid  output  1  one-cycle strobe marking a new bcd_out.
REQ-009 SHALL have port ovf  output  1  last converted value exceeded 10^DIGITS-1.
REQ-010 SHALL have port busy  output  1  conversion in progress.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE, data_valid=1 at an edge SHALL latch data_fx, clear the BCD scratch register, load shift counter 0 and enter SHIFT.
REQ-013 SHIFT SHALL run shift-add-3 (double-dabble), one input bit per cycle, MSB first, for exactly DATA_W cycles, then enter DONE.
REQ-014 Each SHIFT cycle SHALL add 3 to every scratch nibble >=5 before the 1-bit left shift; the shift counter SHALL be ceil(log2(DATA_W+1)) bits wide.
REQ-015 DONE SHALL last one cycle: bcd_out and ovf registered, bcd_valid=1, then return to IDLE.
REQ-016 If data_valid is sampled at edge N, bcd_valid SHALL be high in the cycle following edge N+DATA_W+1.
REQ-017 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-018 data_valid in SHIFT or DONE SHALL be ignored, with no effect on the conversion in progress or on any output.
REQ-019 data_valid in the first IDLE cycle after DONE SHALL be accepted, giving a back-to-back throughput of one result per DATA_W+2 cycles.
REQ-020 If the latched value exceeds 10^DIGITS-1, bcd_out SHALL be all digits 9, ovf=1, with unchanged latency; otherwise ovf=0.
REQ-021 bcd_out and ovf SHALL hold their value between bcd_valid strobes.

Reset
REQ-022 sys_rst_n=0 SHALL immediately force the FSM to IDLE and set bcd_out=0, ovf=0, bcd_valid=0, busy=0, independent of sys_clk.
REQ-023 A reset during SHIFT or DONE SHALL abort the conversion with no bcd_valid issued; the first edge after release SHALL be treated as IDLE.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN defined: every leading zero digit in bcd_out SHALL be replaced by 4'hF (LCD blank code); the least significant digit SHALL never be blanked.
REQ-025 Macro LEADING_ZERO_BLANK_EN undefined: bcd_out SHALL carry plain BCD with leading zeros, and no blanking logic SHALL be synthesized.

Verification
REQ-026 data_fx=5_000_000 strobed -> bcd_valid exactly 31 cycles later, bcd_out=36'h005000000, ovf=0 (36'hFF5000000 with blanking).
REQ-027 data_fx=0 -> bcd_out=36'h000000000 (36'hFFFFFFFF0 with blanking); data_fx=999_999_999 -> 36'h999999999, ovf=0.
REQ-028 data_fx=1_000_000_000 -> bcd_out=36'h999999999, ovf=1; a following data_fx=12 -> 36'h000000012 (36'hFFFFFFF12 with blanking), ovf=0.
REQ-029 data_fx=123 strobed, then data_valid with 456 at cycle 5 of SHIFT -> single bcd_valid, bcd_out=36'h000000123; 456 strobed first IDLE cycle after DONE -> 36'h000000456 31 cycles later.
REQ-030 sys_rst_n pulsed low at SHIFT cycle 10 -> all outputs 0 asynchronously, no bcd_valid for that conversion; next strobe of 7 converts normally to 36'h000000007.
